// File: rtl/regbank_writeback_pkg.sv
// Shared write-back definitions: default widths, register-zero constant and
// the {addr, data} entry type used by the bank, decode and write-back stages.
package regbank_writeback_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regbank_writeback_fifo.sv
// In-order circular queue for write-back entries; exposes storage and a
// per-slot valid mask so the top can search pending results.
module wb_fifo
    import regbank_writeback_pkg::*;
#(
    parameter int W     = WB_ADDR_W + WB_DATA_W,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count,
    output logic [PW-1:0]             rd_ptr,
    output logic [DEPTH-1:0][W-1:0]   entries,
    output logic [DEPTH-1:0]          valid_mask
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        logic [PW-1:0] off;
        off        = '0;
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = PW'(i) - rd_ptr;
            valid_mask[i] = ({1'b0, off} < count);
        end
    end

endmodule

// File: rtl/regbank_writeback.sv
// Write-back sequencer for the register bank write port.
// Optional bypass search enabled by REGBANK_WB_BYPASS_EN.
module regbank_writeback
    import regbank_writeback_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_addr,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       wb_stall,
    output logic                       write_en,
    output logic [ADDR_W-1:0]          addrWrite,
    output logic [DATA_W-1:0]          dataIn,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int W  = ADDR_W + DATA_W;

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    mem_fire;
    logic                    alu_fire;
    logic [ADDR_W-1:0]       in_addr;
    logic [DATA_W-1:0]       in_data;
    logic [W-1:0]            head;
    logic [PW-1:0]           rd_ptr;
    logic [DEPTH-1:0][W-1:0] entries;
    logic [DEPTH-1:0]        valid_mask;
    logic [CW-1:0]           count;

    // Loads win arbitration: they belong to the older instruction.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign in_addr   = mem_fire ? mem_addr : alu_addr;
    assign in_data   = mem_fire ? mem_data : alu_data;
    assign push      = (mem_fire || alu_fire) && (in_addr != REG_ZERO);
    assign pop       = !empty && !wb_stall;
    assign occupancy = count;

    wb_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({in_addr, in_data}),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .rd_ptr     (rd_ptr),
        .entries    (entries),
        .valid_mask (valid_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            write_en  <= 1'b0;
            addrWrite <= '0;
            dataIn    <= '0;
        end else begin
            write_en <= pop;
            if (pop) begin
                addrWrite <= head[W-1 -: ADDR_W];
                dataIn    <= head[DATA_W-1:0];
            end
        end
    end

`ifdef REGBANK_WB_BYPASS_EN
    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (write_en && addrWrite == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = dataIn;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid_mask[idx] && entries[idx][W-1 -: ADDR_W] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx][DATA_W-1:0];
            end
        end
        if (fwd_addr == REG_ZERO) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{fwd_addr, entries, valid_mask, rd_ptr};
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_regbank_writeback.sv
// Directed bench for regbank_writeback: handshake, ordering, reg-0 filter,
// stall/fill, bypass and reset behaviour.
module tb_regbank_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        wb_stall;
    logic        write_en;
    logic [4:0]  addrWrite;
    logic [31:0] dataIn;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REGBANK_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regbank_writeback #(
        .DATA_W (32),
        .ADDR_W (5),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .wb_stall  (wb_stall),
        .write_en  (write_en),
        .addrWrite (addrWrite),
        .dataIn    (dataIn),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_fwd(input string tag, input logic [4:0] a,
                             input logic [31:0] val);
        fwd_addr = a;
        #1;
        check({tag, "_hit"}, 32'(fwd_hit), BYP ? 32'(val != 0) : 32'd0);
        check({tag, "_data"}, fwd_data, BYP ? val : 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        wb_stall  = 1'b0;
        fwd_addr  = '0;
        step();
        step();
        check("rst_we", 32'(write_en), 0);
        check("rst_aw", 32'(addrWrite), 0);
        check("rst_di", dataIn, 0);
        check("rst_occ", 32'(occupancy), 0);
        reset = 1'b0;
        #1;
        check("rst_mrdy", 32'(mem_ready), 1);
        check("rst_ardy", 32'(alu_ready), 1);

        // single ALU result
        alu_valid = 1'b1;
        alu_addr  = 5'd3;
        alu_data  = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        check("t1_occ1", 32'(occupancy), 1);
        check("t1_we0", 32'(write_en), 0);
        step();
        check("t1_we", 32'(write_en), 1);
        check("t1_aw", 32'(addrWrite), 3);
        check("t1_di", dataIn, 32'hDEADBEEF);
        check("t1_occ0", 32'(occupancy), 0);
        step();
        check("t1_we_off", 32'(write_en), 0);

        // simultaneous sources
        mem_valid = 1'b1;
        mem_addr  = 5'd5;
        mem_data  = 32'h11;
        alu_valid = 1'b1;
        alu_addr  = 5'd6;
        alu_data  = 32'h22;
        #1;
        check("t2_mrdy", 32'(mem_ready), 1);
        check("t2_ardy0", 32'(alu_ready), 0);
        step();
        mem_valid = 1'b0;
        #1;
        check("t2_ardy1", 32'(alu_ready), 1);
        step();
        alu_valid = 1'b0;
        check("t2_we_a", 32'(write_en), 1);
        check("t2_aw_a", 32'(addrWrite), 5);
        check("t2_di_a", dataIn, 32'h11);
        step();
        check("t2_we_b", 32'(write_en), 1);
        check("t2_aw_b", 32'(addrWrite), 6);
        check("t2_di_b", dataIn, 32'h22);
        step();
        check("t2_we_off", 32'(write_en), 0);
        check("t2_occ", 32'(occupancy), 0);

        // register 0 is dropped
        mem_valid = 1'b1;
        mem_addr  = 5'd0;
        mem_data  = 32'hFFFFFFFF;
        #1;
        check("t3_mrdy", 32'(mem_ready), 1);
        step();
        mem_valid = 1'b0;
        check("t3_occ", 32'(occupancy), 0);
        check("t3_we", 32'(write_en), 0);
        step();
        check("t3_we2", 32'(write_en), 0);
        check("t3_aw_hold", 32'(addrWrite), 6);
        check("t3_di_hold", dataIn, 32'h22);

        // stall and fill
        wb_stall  = 1'b1;
        alu_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_addr = 5'(i);
            alu_data = 32'h100 + 32'(i);
            step();
            check("t4_we_stall", 32'(write_en), 0);
        end
        alu_valid = 1'b0;
        check("t4_occ4", 32'(occupancy), 4);
        check("t4_mrdy0", 32'(mem_ready), 0);
        check("t4_ardy0", 32'(alu_ready), 0);
        wb_stall = 1'b0;
        #1;
        check("t4_ardy_pop", 32'(alu_ready), 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t4_we", 32'(write_en), 1);
            check("t4_aw", 32'(addrWrite), 32'(i));
            check("t4_di", dataIn, 32'h100 + 32'(i));
            if (i == 1) begin
                check("t4_ardy1", 32'(alu_ready), 1);
                check("t4_occ3", 32'(occupancy), 3);
            end
        end
        step();
        check("t4_we_off", 32'(write_en), 0);

        // bypass
        wb_stall  = 1'b1;
        alu_valid = 1'b1;
        alu_addr  = 5'd7;
        alu_data  = 32'h1;
        step();
        alu_data  = 32'h2;
        step();
        alu_addr  = 5'd9;
        alu_data  = 32'h99;
        step();
        alu_valid = 1'b0;
        check_fwd("t5_q7", 5'd7, 32'h2);
        check_fwd("t5_q9", 5'd9, 32'h99);
        check_fwd("t5_r0", 5'd0, 32'h0);
        check_fwd("t5_miss", 5'd8, 32'h0);
        wb_stall = 1'b0;
        step();
        check("t5_aw", 32'(addrWrite), 7);
        check("t5_di", dataIn, 32'h1);
        check_fwd("t5_q_over_out", 5'd7, 32'h2);
        step();
        check_fwd("t5_out", 5'd7, 32'h2);
        step();
        check_fwd("t5_out9", 5'd9, 32'h99);
        step();
        check("t5_we_off", 32'(write_en), 0);
        check_fwd("t5_idle", 5'd9, 32'h0);

        // reset mid-operation
        wb_stall  = 1'b1;
        alu_valid = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            alu_addr = 5'(i);
            alu_data = 32'h200 + 32'(i);
            step();
        end
        alu_valid = 1'b0;
        check("t6_occ3", 32'(occupancy), 3);
        reset    = 1'b1;
        wb_stall = 1'b0;
        step();
        reset = 1'b0;
        check("t6_we", 32'(write_en), 0);
        check("t6_occ", 32'(occupancy), 0);
        check("t6_aw", 32'(addrWrite), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_write", 32'(write_en), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_writeback.md
# regbank_writeback

Write-back sequencer driving the single write port of the 32×32 register bank. It accepts results from the ALU path and the memory (load) path through valid/ready handshakes. Results go into one in-order queue and are presented to the bank one per cycle as registered `write_en`/`addrWrite`/`dataIn`. An optional bypass lookup returns values still pending in the sequencer, so the decode stage sees them before they reach the bank.

## Interface
- `DATA_W`, 32, result/data width
- `ADDR_W`, 5, register address width
- `DEPTH`, 4, queue entries (power of two, ≥2)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_valid`  in  1  load result valid
- `mem_ready`  out  1  load result accepted this edge
- `mem_addr`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load result
- `alu_valid`  in  1  ALU result valid
- `alu_ready`  out  1  ALU result accepted this edge
- `alu_addr`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `wb_stall`  in  1  freeze bank writes (no dequeue)
- `write_en`  out  1  bank write strobe (registered)
- `addrWrite`  out  ADDR_W  bank write address (registered)
- `dataIn`  out  DATA_W  bank write data (registered)
- `fwd_addr`  in  ADDR_W  bypass lookup address
- `fwd_hit`  out  1  pending value exists for `fwd_addr`
- `fwd_data`  out  DATA_W  youngest pending value for `fwd_addr`
- `occupancy`  out  clog2(DEPTH)+1  entries currently queued

## Operation
- **Queue.** Circular buffer of {addr, data}, with read/write pointers and a count. At most one enqueue and one dequeue per cycle.
- **Ready signals.** `mem_ready = !full`. `alu_ready = !full && !mem_valid`: load has priority, because it is the older instruction. Both are computed from the registered count only; a same-cycle dequeue never frees a slot for that cycle's enqueue.
- **Handshake.** A transfer occurs when valid && ready at the edge. The producer holds addr/data stable while valid && !ready.
- **Register 0.** A transfer whose addr is 0 completes the handshake but is not stored, so occupancy is unchanged.
- **Dequeue.** On each edge where !empty && !wb_stall, the head is popped into the output registers with `write_en`=1. Otherwise `write_en`=0 on that edge, and `addrWrite`/`dataIn` hold their last values.
- **Simultaneous enqueue and dequeue.** When non-empty, the count is unchanged and both pointers advance.
- **Pointer wrap-around.** Pointers wrap modulo DEPTH.
- **Bypass.** Combinational search over valid queue entries plus the output register while `write_en`=1. The youngest match wins, with order queue tail → head → output register.
  - `fwd_hit`=0 when `fwd_addr`==0 or there is no match.
  - `fwd_data`=0 when there is no hit.

## Timing
- **Reset state.** `write_en`=0, `addrWrite`=0, `dataIn`=0, `occupancy`=0, and pointers are 0.
  - `mem_ready`=`alu_ready`=1 in the cycle after reset deasserts (subject to `mem_valid` for `alu_ready`).
- **Latency.** A result accepted at edge N into an empty, unstalled queue has `write_en`=1 during cycle N+1. The bank captures it at edge N+2.
- **Throughput.** One write per cycle sustained.
- **Full queue.** With DEPTH entries queued, both readies are 0 even if a dequeue happens that cycle; they reassert in the following cycle.
- **Reset mid-operation.** Queued entries are discarded, not written. `write_en` drops at the reset edge.
- **Stall.** `wb_stall` has effect at the same edge and causes no extra bubble when released.

## Configuration
- `REGBANK_WB_BYPASS_EN`
  - **Defined:** the bypass search is built as described above.
  - **Undefined:** `fwd_hit`=0 and `fwd_data`=0 constantly, with no search logic; `fwd_addr` is ignored. Queue behaviour is identical either way.

## Structure
- **Shared package:** `DATA_W`/`ADDR_W` defaults, the `REG_ZERO` constant (5'd0), and the `wb_entry_t` typedef {addr, data}. The package is shared with the register bank and the decode stage.
- **Sub-module:** `wb_fifo` (storage, pointers, count, full/empty).
  - It exposes its entry array and valid mask for the bypass search.
  - The arbitration, register-0 filter, output register and bypass logic stay in the top module.

## Test plan
- **Single ALU result.** After reset, ALU writes addr 3 data 0xDEADBEEF → `write_en`=1 with addrWrite=3, dataIn=0xDEADBEEF exactly one cycle after acceptance; occupancy returns to 0.
- **Simultaneous sources.** mem (addr 5, 0x11) and alu (addr 6, 0x22) valid together → mem accepted first and `alu_ready`=0 that cycle; bank writes 5 then 6 on consecutive cycles.
- **Register 0.** mem addr 0 data 0xFFFFFFFF → handshake completes, occupancy stays 0, `write_en` never asserts.
- **Stall and fill.** `wb_stall`=1 with 4 ALU writes (addr 1–4) → occupancy=4, both readies 0. Release the stall → four consecutive writes in order 1,2,3,4, and `alu_ready` returns the cycle after the first pop.
- **Bypass.** With the macro defined, queue addr 7=0x1 then addr 7=0x2 under stall; `fwd_addr`=7 → hit, 0x2. With `fwd_addr`=0 → no hit. With the macro undefined → `fwd_hit`=0 always.
- **Reset mid-operation.** Reset asserted with 3 entries queued → next cycle `write_en`=0, occupancy=0, and no queued value is ever written.
